// File: rtl/clk_div_monitor.sv
// Receive-side checker for a generated clock. mon_clk is oversampled in the
// clk_in domain and its rise-to-rise period and rise-to-fall high time are
// measured in clk_in cycles, then compared against an expected divide ratio.
// The block also flags out-of-tolerance periods (sticky) and stalls (stuck).
module clk_div_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int TOL     = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] expected_div,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             ratio_ok,
  output logic             err_sticky,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_shadow_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             meas_valid_q, ratio_ok_q, err_q, stuck_q;

  logic             rise, fall;
  logic             active;
  logic             timeout;
  logic [CNT_W:0]   cnt_x, exp_x, diff;
  logic             in_tol;

  // Two-flop synchroniser plus an edge register; runs regardless of state.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= mon_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign active  = (state_q == ARM || state_q == MEAS) && enable;
  assign timeout = active && !rise && (cnt_q == TIMEOUT_C);

  // Tolerance check in CNT_W+1 bits so the difference can never wrap.
  always_comb begin
    cnt_x  = {1'b0, cnt_q};
    exp_x  = {1'b0, expected_div};
    diff   = (cnt_x >= exp_x) ? (cnt_x - exp_x) : (exp_x - cnt_x);
    in_tol = (expected_div == '0) || (diff <= TOL_C);
  end

  // Cycle counter: restart on each rise, cleared when idle or on timeout,
  // otherwise counts up and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!active)             cnt_d = '0;
    else if (rise)           cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (timeout)        cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Measurement FSM with registered outputs. Later assignments win, so a
  // set of err/stuck overrides a clr issued in the same cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      high_shadow_q <= '0;
      period_q      <= '0;
      high_q        <= '0;
      meas_valid_q  <= 1'b0;
      ratio_ok_q    <= 1'b0;
      err_q         <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      meas_valid_q <= 1'b0;
      if (clr) begin
        err_q   <= 1'b0;
        stuck_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (enable) state_q <= ARM;
        end
        ARM, MEAS: begin
          if (!enable) begin
            // Drop whatever was in flight; the next enable re-arms.
            state_q <= IDLE;
          end else if (rise) begin
            stuck_q <= 1'b0;
            state_q <= MEAS;
            // A rise seen in ARM only starts the first full period.
            if (state_q == MEAS) begin
              period_q     <= cnt_q;
              high_q       <= high_shadow_q;
              meas_valid_q <= 1'b1;
              ratio_ok_q   <= in_tol;
              if (!in_tol) err_q <= 1'b1;
            end
          end else if (timeout) begin
            stuck_q <= 1'b1;
            state_q <= ARM;
          end else if (fall && state_q == MEAS) begin
            high_shadow_q <= cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign ratio_ok   = ratio_ok_q;
  assign err_sticky = err_q;
  assign stuck      = stuck_q;

endmodule
